// File: rtl/konami_pkg.sv
// konami_pkg: shared definitions for the Konami-code detector.
//   key_e      3-bit key codes, UP=0 .. START=6, INVALID=7
//   SEQ_LEN    number of elements in the code
//   SEQ        the code itself, U U D D L R L R B A START
//   PROGRESS_W width of the progress (matched-element) count
//   seq_key()  expected key at a given progress, INVALID if out of range
package konami_pkg;

    typedef enum logic [2:0] {
        KEY_UP      = 3'd0,
        KEY_DOWN    = 3'd1,
        KEY_LEFT    = 3'd2,
        KEY_RIGHT   = 3'd3,
        KEY_B       = 3'd4,
        KEY_A       = 3'd5,
        KEY_START   = 3'd6,
        KEY_INVALID = 3'd7
    } key_e;

    localparam int SEQ_LEN    = 11;
    localparam int PROGRESS_W = 4;

    localparam key_e SEQ [SEQ_LEN] = '{
        KEY_UP, KEY_UP, KEY_DOWN, KEY_DOWN, KEY_LEFT, KEY_RIGHT,
        KEY_LEFT, KEY_RIGHT, KEY_B, KEY_A, KEY_START
    };

    localparam logic [PROGRESS_W-1:0] LAST_IDX = PROGRESS_W'(SEQ_LEN - 1);

    // Constant-index lookup so an out-of-range progress can never index
    // past the table; it simply yields INVALID, which matches nothing.
    function automatic key_e seq_key(input logic [PROGRESS_W-1:0] k);
        key_e r;
        r = KEY_INVALID;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (k == PROGRESS_W'(i)) r = SEQ[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/konami_sequence_detector_key_event_encoder.sv
// key_event_encoder: turns debounced button levels into single press events.
//   clk, reset   clock, asynchronous active-high reset
//   btn[6:0]     debounced levels: UP, DOWN, LEFT, RIGHT, B, A, START
//   press_valid  high in any cycle where some button rises
//   key_code     pressed key, or INVALID for chords / multiple rises
// Both outputs are combinational from btn and the registered btn_q.
module key_event_encoder
    import konami_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] btn,
    output logic       press_valid,
    output key_e       key_code
);

    logic [6:0] btn_q;
    logic       armed;
    logic [6:0] rise;
    logic       one_hot;

    // btn_q resets to 0, so a button already held when reset drops would
    // look like a rise. The first cycle after reset only loads btn_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= '0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn;
            armed <= 1'b1;
        end
    end

    always_comb begin
        rise        = btn & ~btn_q;
        one_hot     = (btn != 7'd0) && ((btn & (btn - 7'd1)) == 7'd0);
        press_valid = armed && (rise != 7'd0);
        key_code    = KEY_INVALID;
        // A valid key is the only button down and it is the one that rose.
        if (one_hot && (rise == btn)) begin
            for (int i = 0; i < 7; i++) begin
                if (btn[i]) key_code = key_e'(3'(i));
            end
        end
    end

endmodule

// File: rtl/konami_sequence_detector.sv
// konami_sequence_detector: recognises U U D D L R L R B A START.
//   TIMEOUT_W  width of the inactivity counter
//   TIMEOUT    idle cycles before partial progress is dropped (0 = never)
//   clk, reset clock, asynchronous active-high reset
//   btn[6:0]   debounced button levels
//   unlock     one-cycle pulse when the full code is accepted
//   error      one-cycle pulse when a press breaks a partial match
//   progress   number of code elements currently matched, 0..10
module konami_sequence_detector
    import konami_pkg::*;
#(
    parameter int                    TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT   = 24'd10_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            btn,
    output logic                  unlock,
    output logic                  error,
    output logic [PROGRESS_W-1:0] progress
);

    localparam logic [TIMEOUT_W-1:0] TO_MAX = TIMEOUT - TIMEOUT_W'(1);
    localparam bit                   TO_EN  = (TIMEOUT != '0);

    logic                  press;
    key_e                  key_code;
    key_e                  expected;
    logic                  match;
    logic                  timeout_hit;
    logic [PROGRESS_W-1:0] progress_nxt;
    logic                  unlock_nxt;
    logic                  error_nxt;
    logic [TIMEOUT_W-1:0]  idle_cnt;
    logic [TIMEOUT_W-1:0]  idle_cnt_nxt;

    key_event_encoder u_enc (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .press_valid (press),
        .key_code    (key_code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            progress <= '0;
            unlock   <= 1'b0;
            error    <= 1'b0;
            idle_cnt <= '0;
        end else begin
            progress <= progress_nxt;
            unlock   <= unlock_nxt;
            error    <= error_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        expected     = seq_key(progress);
        match        = (key_code == expected) && (key_code != KEY_INVALID);
        timeout_hit  = TO_EN && (progress != '0) && (idle_cnt == TO_MAX) && !press;
        progress_nxt = progress;
        unlock_nxt   = 1'b0;
        error_nxt    = 1'b0;

        if (press) begin
            if (match) begin
                if (progress == LAST_IDX) begin
                    unlock_nxt   = 1'b1;
                    progress_nxt = '0;
                end else begin
                    progress_nxt = progress + PROGRESS_W'(1);
                end
            end else begin
                error_nxt = (progress != '0);
                // KMP fallback: only UP can restart a match. After "U U" an
                // extra UP still leaves "U U" as the longest matching suffix.
                if (key_code == KEY_UP) begin
                    progress_nxt = (progress == PROGRESS_W'(2)) ? PROGRESS_W'(2)
                                                                : PROGRESS_W'(1);
                end else begin
                    progress_nxt = '0;
                end
            end
        end else if (timeout_hit) begin
            progress_nxt = '0;
        end

        // Idle counter runs only while a partial entry is pending.
        if (press || (progress == '0)) begin
            idle_cnt_nxt = '0;
        end else if (idle_cnt == TO_MAX) begin
            idle_cnt_nxt = idle_cnt;
        end else begin
            idle_cnt_nxt = idle_cnt + TIMEOUT_W'(1);
        end
    end

endmodule

// File: tb/tb_konami_sequence_detector.sv
// tb_konami_sequence_detector: scoreboard bench for konami_sequence_detector.
// Stimulus pushes the hand-computed expected outputs for the edge that will
// sample it; the monitor pops and compares once per cycle on the falling edge.
module tb_konami_sequence_detector;

    localparam int KU = 0, KD = 1, KL = 2, KR = 3, KB = 4, KA = 5, KS = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] btn = 7'd0;
    logic       unlock;
    logic       error;
    logic [3:0] progress;

    typedef struct {
        int    cyc;
        int    p;
        bit    u;
        bit    e;
        string tag;
    } exp_t;

    exp_t  q[$];
    int    cyc    = 0;
    int    n_cmp  = 0;
    int    n_fail = 0;
    string phase  = "reset";

    konami_sequence_detector #(
        .TIMEOUT_W (24),
        .TIMEOUT   (24'd16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .unlock   (unlock),
        .error    (error),
        .progress (progress)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are presented every cycle, check the entry due now.
    always @(negedge clk) begin
        exp_t x;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            x = q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", x.tag, x.cyc, cyc);
        end
        while (q.size() > 0 && q[0].cyc == cyc) begin
            x = q.pop_front();
            n_cmp++;
            if (progress !== 4'(x.p) || unlock !== x.u || error !== x.e) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got progress=%0d unlock=%b error=%b, want progress=%0d unlock=%b error=%b",
                         x.tag, cyc, progress, unlock, error, x.p, x.u, x.e);
            end
        end
    end

    // One cycle of stimulus. now=1 means the effect is visible in this same
    // cycle (asynchronous reset), replacing whatever this edge had produced.
    task automatic drive(input logic [6:0] b, input logic r, input int p,
                         input bit u, input bit e, input bit now);
        exp_t x;
        @(posedge clk);
        #1;
        btn   = b;
        reset = r;
        if (now && q.size() > 0 && q[$].cyc == cyc) void'(q.pop_back());
        x.cyc = now ? cyc : cyc + 1;
        x.p   = p;
        x.u   = u;
        x.e   = e;
        x.tag = phase;
        q.push_back(x);
    endtask

    function automatic logic [6:0] key_bit(input int k);
        logic [6:0] b;
        b    = '0;
        b[k] = 1'b1;
        return b;
    endfunction

    // Press for one cycle then release for two.
    task automatic tap(input int k, input int p, input bit u, input bit e);
        drive(key_bit(k), 1'b0, p, u, e, 1'b0);
        drive(7'd0, 1'b0, p, 1'b0, 1'b0, 1'b0);
        drive(7'd0, 1'b0, p, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic full_code();
        tap(KU, 1, 0, 0);  tap(KU, 2, 0, 0);  tap(KD, 3, 0, 0);
        tap(KD, 4, 0, 0);  tap(KL, 5, 0, 0);  tap(KR, 6, 0, 0);
        tap(KL, 7, 0, 0);  tap(KR, 8, 0, 0);  tap(KB, 9, 0, 0);
        tap(KA, 10, 0, 0); tap(KS, 0, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        phase = "reset";
        drive(7'd0, 1'b1, 0, 0, 0, 0);
        drive(7'd0, 1'b1, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);

        phase = "full_code";
        full_code();

        phase = "triple_up";
        tap(KU, 1, 0, 0); tap(KU, 2, 0, 0); tap(KU, 2, 0, 1);
        tap(KD, 3, 0, 0); tap(KD, 4, 0, 0); tap(KL, 5, 0, 0);
        tap(KR, 6, 0, 0); tap(KL, 7, 0, 0); tap(KR, 8, 0, 0);
        tap(KB, 9, 0, 0); tap(KA, 10, 0, 0); tap(KS, 0, 1, 0);

        phase = "mismatch_k5";
        tap(KU, 1, 0, 0); tap(KU, 2, 0, 0); tap(KD, 3, 0, 0);
        tap(KD, 4, 0, 0); tap(KL, 5, 0, 0); tap(KB, 0, 0, 1);
        phase = "up_at_k5";
        tap(KU, 1, 0, 0); tap(KU, 2, 0, 0); tap(KD, 3, 0, 0);
        tap(KD, 4, 0, 0); tap(KL, 5, 0, 0); tap(KU, 1, 0, 1);

        phase = "chord_k2";
        drive(key_bit(KU), 1'b0, 2, 0, 0, 0);
        drive(key_bit(KU), 1'b0, 2, 0, 0, 0);
        drive(key_bit(KU) | key_bit(KD), 1'b0, 0, 0, 1, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);

        phase = "double_rise_k0";
        drive(key_bit(KU) | key_bit(KD), 1'b0, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);
        tap(KD, 0, 0, 0);

        phase = "back_to_back";
        drive(key_bit(KU), 1'b0, 1, 0, 0, 0);
        drive(key_bit(KD), 1'b0, 0, 0, 1, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);

        phase = "timeout";
        drive(key_bit(KU), 1'b0, 1, 0, 0, 0);
        drive(key_bit(KU), 1'b0, 1, 0, 0, 0);
        drive(key_bit(KU), 1'b0, 1, 0, 0, 0);
        for (int i = 0; i < 13; i++) drive(7'd0, 1'b0, 1, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);

        phase = "press_at_timeout";
        drive(key_bit(KU), 1'b0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) drive(7'd0, 1'b0, 1, 0, 0, 0);
        drive(key_bit(KU), 1'b0, 2, 0, 0, 0);
        drive(7'd0, 1'b0, 2, 0, 0, 0);
        tap(KL, 0, 0, 1);

        phase = "held_through_reset";
        drive(key_bit(KU), 1'b1, 0, 0, 0, 0);
        drive(key_bit(KU), 1'b1, 0, 0, 0, 0);
        drive(key_bit(KU), 1'b0, 0, 0, 0, 0);
        drive(key_bit(KU), 1'b0, 0, 0, 0, 0);
        drive(key_bit(KU), 1'b0, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);

        phase = "reset_at_k7";
        tap(KU, 1, 0, 0); tap(KU, 2, 0, 0); tap(KD, 3, 0, 0);
        tap(KD, 4, 0, 0); tap(KL, 5, 0, 0); tap(KR, 6, 0, 0);
        tap(KL, 7, 0, 0);
        drive(7'd0, 1'b1, 0, 0, 0, 1);
        drive(7'd0, 1'b1, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);
        drive(7'd0, 1'b0, 0, 0, 0, 0);

        phase = "after_reset";
        full_code();
        drive(7'd0, 1'b0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/konami_sequence_detector.md
# konami_sequence_detector

Consumes the seven debounced button levels and recognises the code UP UP DOWN DOWN LEFT RIGHT LEFT RIGHT B A START. It is the stage directly downstream of the per-button debouncers. It converts level changes into single key-press events and tracks progress through the sequence with a KMP-style matcher. It times out stalled partial entries and emits a one-cycle unlock pulse on completion.

## Interface
- TIMEOUT_W, 24: width of the inactivity counter.
- TIMEOUT, 24'd10_000_000: cycles without a press before partial progress is discarded; 0 disables the timeout.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn  input  7  debounced button levels: [0]=UP, [1]=DOWN, [2]=LEFT, [3]=RIGHT, [4]=B, [5]=A, [6]=START.
- unlock  output  1  one-cycle pulse when the full sequence is accepted.
- error  output  1  one-cycle pulse when a press breaks a partial match (progress ≥1).
- progress  output  4  number of sequence elements currently matched, 0..10.

## Operation
- Edge detect: a registered copy btn_q holds the previous cycle's btn. rise = btn & ~btn_q.
- Press event: fires in any cycle where rise != 0.
  - Valid key: exactly one bit of btn is high and it is the rising bit. Its index gives the key code.
  - INVALID code: any other case, e.g. a second button held or two buttons rising together. INVALID matches nothing.
- Sequence SEQ[0..10] = U U D D L R L R B A S. State k = progress.
- On a press with key c at state k:
  - c == SEQ[k] and k < 10: next k+1.
  - c == SEQ[10] at k == 10: unlock pulse; next 0.
  - mismatch with c == UP: next 2 if k == 2, else 1.
  - mismatch otherwise, including INVALID: next 0.
  - error pulses on any mismatch where k ≥ 1. It also pulses for mismatch-with-UP that lands in state 1 or 2.
- Releases (falling edges) are ignored.
- Timeout counter:
  - Clears on every press event and whenever k == 0.
  - Otherwise increments, saturating at TIMEOUT-1.
  - When k != 0, TIMEOUT != 0 and the count == TIMEOUT-1 with no press this cycle: next k = 0. No error pulse.
- Press and timeout in the same cycle: the press wins and is evaluated against the current k.

## Timing
- Reset values: unlock=0, error=0, progress=0, btn_q=0, timeout counter=0.
- Latency: btn rising before edge N causes progress, unlock and error to update after edge N. That is one cycle, with all outputs registered.
- unlock and error are high for exactly one cycle. They never assert together.
- A button held high produces exactly one event. Re-pressing requires a low for at least one sampled cycle.
- Back-to-back presses on consecutive cycles are each processed. There is no stall and no handshake.
- Reset asserted mid-sequence clears progress and counter immediately. A button already high when reset deasserts produces no event, because btn_q is 0 so rise would fire. The implementation must therefore load btn_q from btn on the first cycle after reset and suppress events in that cycle.

## Structure
- Package konami_pkg:
  - key codes (3-bit: UP=0 … START=6, INVALID=7)
  - SEQ_LEN=11
  - SEQ constant array
  - PROGRESS_W=4
- Sub-module key_event_encoder: btn_q register, first-cycle suppression, rise/one-hot check. Outputs press_valid and key_code[2:0], both combinational from registered btn_q.
- Top: matcher FSM (progress register plus next-state logic above), timeout counter, registered pulse outputs.

## Test plan
- Full code, one cycle per press with 2-cycle releases: progress steps 1..10 → unlock=1 for one cycle after START; progress=0; error never high.
- U U U D D L R L R B A S: third U gives error=1 and progress stays 2. Remaining presses → unlock.
- Mismatch at k=5 (B instead of R): error=1, progress=0. Then mismatch UP at k=5 after re-entry gives progress=1.
- Chord: UP held, then DOWN rises at k=2 → INVALID, error=1, progress=0. Simultaneous UP+DOWN rise at k=0 → progress 0, no error.
- TIMEOUT=16, press U then idle → progress returns to 0 exactly 16 cycles after the press edge, no error. A press on the 16th cycle advances instead.
- Hold UP through reset deassertion → no event, progress=0. Assert reset at k=7 → progress=0 asynchronously, unlock stays 0.
